code_entry: RTL and testbench

Upstream digit-entry stage of the combination lock. It debounces the four push-buttons, collects up to DIGITS decimal digits from the switch bank, and drives one seven-segment pattern plus its digit position per accepted keystroke. When the user submits a complete code it raises a single-cycle `done` pulse with the packed code. The lock controller consumes these outputs to set the password, check an attempt, or mirror digits onto seg0..seg5.

---
 rtl/code_entry.sv | 192 +++++++++++++++++++
 tb/tb_code_entry.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/code_entry.sv
// Digit-entry front end for the combination lock: debounced buttons in,
// one seven-segment write per accepted keystroke and a packed code on submit out.
`timescale 1ns/1ps

module code_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q, deb_q, press_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive synced samples that disagree with the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q   <= sync2_q;
        cnt_q   <= '0;
        press_q <= deb_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;
endmodule

module code_entry #(
  parameter int DIGITS          = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MASK            = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [3:0]            num,
  input  logic [3:0]            buttons,
  output logic [6:0]            seg,
  output logic [2:0]            pos,
  output logic                  seg_valid,
  output logic                  done,
  output logic [4*DIGITS-1:0]   code,
  output logic [2:0]            count,
  output logic                  err
);
  localparam int         NUM_LANES = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic {S_ENTRY, S_DONE} state_t;

  logic [NUM_LANES-1:0] ev;

  genvar lane;
  generate
    for (lane = 0; lane < NUM_LANES; lane++) begin : g_btn
      code_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (buttons[lane]),
        .press_o(ev[lane])
      );
    end
  endgenerate

  function automatic logic [6:0] digit_seg(input logic [3:0] n);
    case (n)
      4'd0:    digit_seg = 7'b0000001;
      4'd1:    digit_seg = 7'b1001111;
      4'd2:    digit_seg = 7'b0010010;
      4'd3:    digit_seg = 7'b0000110;
      4'd4:    digit_seg = 7'b1001100;
      4'd5:    digit_seg = 7'b0100100;
      4'd6:    digit_seg = 7'b0100000;
      4'd7:    digit_seg = 7'b0001111;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0000100;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [6:0]          seg_q, seg_d;
  logic [2:0]          pos_q, pos_d;
  logic [2:0]          count_q, count_d;
  logic [4*DIGITS-1:0] code_q, code_d;
  logic                seg_valid_q, seg_valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ENTRY;
      seg_q       <= SEG_BLANK;
      pos_q       <= '0;
      count_q     <= '0;
      code_q      <= '0;
      seg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      pos_q       <= pos_d;
      count_q     <= count_d;
      code_q      <= code_d;
      seg_valid_q <= seg_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Only the highest-priority event of a cycle acts; clear-entry works even when frozen.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    pos_d       = pos_q;
    count_d     = count_q;
    code_d      = code_q;
    seg_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (clear) begin
      count_d = '0;
      code_d  = '0;
      state_d = S_ENTRY;
    end else if (ev[3]) begin
      count_d     = '0;
      code_d      = '0;
      state_d     = S_ENTRY;
      seg_d       = SEG_BLANK;
      pos_d       = '0;
      seg_valid_d = 1'b1;
    end else if (state_q == S_ENTRY) begin
      if (ev[2]) begin
        if (count_q == 3'(DIGITS)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d = 1'b1;
        end
      end else if (ev[1]) begin
        if (count_q == 3'd0) begin
          err_d = 1'b1;
        end else begin
          count_d     = count_q - 3'd1;
          pos_d       = count_q - 3'd1;
          seg_d       = SEG_BLANK;
          seg_valid_d = 1'b1;
          for (int i = 0; i < DIGITS; i++)
            if (3'(i) == count_q - 3'd1) code_d[4*i +: 4] = 4'h0;
        end
      end else if (ev[0]) begin
        if (num > 4'd9 || count_q == 3'(DIGITS)) begin
          err_d = 1'b1;
        end else begin
          count_d     = count_q + 3'd1;
          pos_d       = count_q;
          seg_d       = (MASK != 0) ? SEG_DASH : digit_seg(num);
          seg_valid_d = 1'b1;
          for (int i = 0; i < DIGITS; i++)
            if (3'(i) == count_q) code_d[4*i +: 4] = num;
        end
      end
    end
  end

  assign seg       = seg_q;
  assign pos       = pos_q;
  assign seg_valid = seg_valid_q;
  assign done      = done_q;
  assign code      = code_q;
  assign count     = count_q;
  assign err       = err_q;
endmodule

// File: tb/tb_code_entry.sv
// Scoreboarded bench for code_entry: a digit-list model predicts each strobe,
// a negedge monitor pops and compares whenever the DUT strobes.
`timescale 1ns/1ps

module tb_code_entry;
  localparam int DIGITS = 6;
  localparam int DEB    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clear = 1'b0;
  logic [3:0]          num = 4'h0;
  logic [3:0]          buttons = 4'hF;
  logic [6:0]          seg;
  logic [2:0]          pos;
  logic                seg_valid, done, err;
  logic [4*DIGITS-1:0] code;
  logic [2:0]          count;

  code_entry #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB), .MASK(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .num(num), .buttons(buttons),
    .seg(seg), .pos(pos), .seg_valid(seg_valid), .done(done), .code(code),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 seg write, 1 done, 2 err
    logic [6:0] seg;
    logic [2:0] pos;
    logic [23:0] code;
    int         cnt;
  } exp_t;

  exp_t sbq[$];
  int   digits[$];
  bit   frozen;
  int   total = 0;
  int   bad = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int n);
    logic [6:0] t [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return t[n];
  endfunction

  function automatic logic [23:0] model_code();
    logic [23:0] c = '0;
    foreach (digits[i]) c = c | (24'(digits[i]) << (4 * i));
    return c;
  endfunction

  task automatic expect_ev(input int kind, input logic [6:0] s, input int p);
    exp_t e;
    e.kind = kind; e.seg = s; e.pos = 3'(p);
    e.code = model_code(); e.cnt = digits.size();
    sbq.push_back(e);
  endtask

  // Reference behaviour for one cycle's set of button events.
  task automatic model_apply(input logic [3:0] m, input int n);
    int p;
    if (m[3]) begin
      digits.delete(); frozen = 0;
      expect_ev(0, 7'b1111111, 0);
    end else if (frozen) begin
    end else if (m[2]) begin
      if (digits.size() == DIGITS) begin frozen = 1; expect_ev(1, 7'h0, 0); end
      else expect_ev(2, 7'h0, 0);
    end else if (m[1]) begin
      if (digits.size() == 0) expect_ev(2, 7'h0, 0);
      else begin
        void'(digits.pop_back());
        p = digits.size();
        expect_ev(0, 7'b1111111, p);
      end
    end else if (m[0]) begin
      if (n > 9 || digits.size() == DIGITS) expect_ev(2, 7'h0, 0);
      else begin
        p = digits.size();
        digits.push_back(n);
        expect_ev(0, pat(n), p);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (seg_valid || done || err)) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe actual=%b%b%b required=none at %0t", done, err, seg_valid, $time);
      end else begin
        mon_e = sbq.pop_front();
        check("strobe_kind", {29'd0, done, err, seg_valid},
              (mon_e.kind == 0) ? 32'd1 : (mon_e.kind == 1) ? 32'd4 : 32'd2);
        if (mon_e.kind == 0) begin
          check("seg", 32'(seg), 32'(mon_e.seg));
          check("pos", 32'(pos), 32'(mon_e.pos));
        end
        check("count_after", 32'(count), mon_e.cnt);
        check("code_after", 32'(code), 32'(mon_e.code));
      end
    end
  end

  task automatic press(input logic [3:0] m, input logic [3:0] n, input int hold, input bit real_ev);
    @(negedge clk);
    num = n;
    buttons = ~m;
    if (real_ev) model_apply(m, int'(n));
    repeat (hold) @(negedge clk);
    buttons = 4'hF;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_model(input string name);
    check({name, "_count"}, 32'(count), digits.size());
    check({name, "_code"}, 32'(code), 32'(model_code()));
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    digits.delete(); frozen = 0;
    repeat (2) @(negedge clk);
    check_model("after_clear");
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_seg"}, 32'(seg), 32'h7F);
    check({name, "_pos"}, 32'(pos), 0);
    check({name, "_count"}, 32'(count), 0);
    check({name, "_code"}, 32'(code), 0);
    check({name, "_strobes"}, {29'd0, seg_valid, done, err}, 0);
  endtask

  initial begin
    logic [3:0] m;
    logic [3:0] n;
    int r;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 1; i <= 6; i++) press(4'b0001, 4'(i), 10, 1);
    press(4'b0100, 4'h0, 10, 1);
    check("code_654321", 32'(code), 32'h654321);
    press(4'b0001, 4'h7, 10, 1);
    check("done_hold_code", 32'(code), 32'h654321);
    pulse_clear();

    press(4'b0001, 4'h3, 3, 0);
    check("glitch_count", 32'(count), 0);
    press(4'b0001, 4'h3, 40, 1);
    check("hold40_count", 32'(count), 1);
    press(4'b0001, 4'hA, 10, 1);
    check("num_a_count", 32'(count), 1);
    for (int i = 0; i < 4; i++) press(4'b0001, 4'(i), 10, 1);
    press(4'b0100, 4'h0, 10, 1);
    press(4'b0001, 4'h9, 10, 1);
    press(4'b0001, 4'h8, 10, 1);
    check_model("seventh");

    pulse_clear();
    press(4'b0010, 4'h0, 10, 1);
    for (int i = 0; i < 3; i++) press(4'b0001, 4'(i + 7), 10, 1);
    press(4'b0010, 4'h0, 10, 1);
    check("bksp_count", 32'(count), 2);
    press(4'b1100, 4'h0, 10, 1);
    check("prio_count", 32'(count), 0);

    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) pulse_clear();
      else begin
        if (r < 9) m = 4'b0001;
        else if (r < 12) m = 4'b0010;
        else if (r < 15) m = 4'b0100;
        else if (r < 16) m = 4'b1000;
        else m = 4'($urandom_range(1, 15));
        n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        press(m, n, $urandom_range(6, 15), 1);
      end
    end
    check_model("random_end");

    pulse_clear();
    for (int i = 0; i < 4; i++) press(4'b0001, 4'(i + 2), 10, 1);
    check("pre_reset_count", 32'(count), 4);
    @(negedge clk); num = 4'h5; buttons = 4'b1110;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    digits.delete(); frozen = 0;
    @(negedge clk); buttons = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_reset_outputs("post_reset");

    check("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
